// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end. It issues sequential reads to an instruction
// memory with a fixed read latency, tracks the reads in flight, and buffers
// the returned words in a circular queue. Decode takes the words through a
// valid/ready handshake. A branch redirect (flush) empties the queue, kills
// every read in flight and restarts fetch at the redirect target.
//
// Ports:
//   iw_clk        clock, all state updates on the rising edge
//   iw_rst_n      synchronous reset, active low
//   ow_mem_addr   memory read address (the current fetch PC, registered)
//   ow_mem_re     read issue strobe (combinational: credit, flush, reset)
//   iw_mem_rdata  read data, valid MEM_LAT cycles after issue
//   iw_flush      redirect request
//   iw_flush_pc   redirect target
//   ow_valid      queue head holds an instruction
//   iw_ready      decode accepts the head this cycle
//   ow_instr      head instruction word
//   ow_pc         PC of the head instruction
//   ow_count      queue occupancy (reads in flight are not counted)
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int                ADDR_W   = 24,
  parameter int                DATA_W   = 24,
  parameter int                DEPTH    = 4,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst_n,
  output logic [ADDR_W-1:0]        ow_mem_addr,
  output logic                     ow_mem_re,
  input  logic [DATA_W-1:0]        iw_mem_rdata,
  input  logic                     iw_flush,
  input  logic [ADDR_W-1:0]        iw_flush_pc,
  output logic                     ow_valid,
  input  logic                     iw_ready,
  output logic [DATA_W-1:0]        ow_instr,
  output logic [ADDR_W-1:0]        ow_pc,
  output logic [$clog2(DEPTH):0]   ow_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Wide enough for count + reads in flight without overflow.
  localparam int SUM_W = $clog2(DEPTH + MEM_LAT + 1) + 1;

  // Fetch PC and in-flight tracking.
  logic [ADDR_W-1:0] fetch_pc;
  logic              slot_live [MEM_LAT];
  logic [ADDR_W-1:0] slot_pc   [MEM_LAT];

  // Queue storage and bookkeeping.
  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_kept;
  logic [CNT_W-1:0]  count_nxt;

  logic [SUM_W-1:0]  live_cnt;
  logic [SUM_W-1:0]  credit_use;
  logic              pop;
  logic              deq;
  logic              enq;
  logic              issue;
  logic [DATA_W-1:0] head_instr_nxt;
  logic [ADDR_W-1:0] head_pc_nxt;

  always_comb begin
    live_cnt = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      live_cnt = live_cnt + SUM_W'(slot_live[i]);
    end
  end

  // pop is the raw handshake; a flush voids it, so only deq moves the queue.
  assign pop = ow_valid & iw_ready;
  assign deq = pop & ~iw_flush;
  // Returns for reads killed by a flush (or landing in the flush cycle) are dropped.
  assign enq = slot_live[MEM_LAT-1] & ~iw_flush;

  // Credit: every live read already has a queue entry reserved, so issuing
  // can never overflow the queue.
  assign credit_use = SUM_W'(count) + live_cnt - SUM_W'(pop);
  assign issue      = iw_rst_n & ~iw_flush & (credit_use < SUM_W'(DEPTH));

  assign ow_mem_re   = issue;
  assign ow_mem_addr = fetch_pc;
  assign ow_count    = count;

  // Next head: if the queue would otherwise be empty the word landing this
  // cycle becomes the head; otherwise the stored entry at the new read pointer.
  always_comb begin
    count_kept = count - CNT_W'(deq);
    rd_ptr_nxt = rd_ptr + PTR_W'(deq);
    count_nxt  = count_kept + CNT_W'(enq);
    if (count_kept == '0) begin
      head_instr_nxt = iw_mem_rdata;
      head_pc_nxt    = slot_pc[MEM_LAT-1];
    end else begin
      head_instr_nxt = q_instr[rd_ptr_nxt];
      head_pc_nxt    = q_pc[rd_ptr_nxt];
    end
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      fetch_pc <= RESET_PC;
      for (int i = 0; i < MEM_LAT; i++) begin
        slot_live[i] <= 1'b0;
      end
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ow_valid <= 1'b0;
      ow_instr <= '0;
      ow_pc    <= '0;
    end else begin
      if (iw_flush) begin
        fetch_pc <= iw_flush_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end

      slot_live[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) begin
        slot_live[i] <= slot_live[i-1] & ~iw_flush;
      end

      if (iw_flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        ow_valid <= 1'b0;
      end else begin
        rd_ptr   <= rd_ptr_nxt;
        wr_ptr   <= wr_ptr + PTR_W'(enq);
        count    <= count_nxt;
        ow_valid <= (count_nxt != '0);
        if (count_nxt != '0) begin
          ow_instr <= head_instr_nxt;
          ow_pc    <= head_pc_nxt;
        end
      end
    end
  end

  // Datapath storage carries no reset; the live bits and pointers qualify it.
  always_ff @(posedge iw_clk) begin
    slot_pc[0] <= fetch_pc;
    for (int i = 1; i < MEM_LAT; i++) begin
      slot_pc[i] <= slot_pc[i-1];
    end
    if (enq) begin
      q_instr[wr_ptr] <= iw_mem_rdata;
      q_pc[wr_ptr]    <= slot_pc[MEM_LAT-1];
    end
  end

  a_no_overflow: assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
    !(enq && !deq && count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: MEM_LAT=1, DEPTH=4
  logic        a_rst_n = 1'b0, a_flush = 1'b0, a_ready = 1'b0;
  logic [23:0] a_flush_pc = '0;
  logic        a_mem_re, a_valid;
  logic [23:0] a_mem_addr, a_rdata, a_instr, a_pc;
  logic [2:0]  a_count;

  // DUT B: MEM_LAT=3, DEPTH=8
  logic        b_rst_n = 1'b0, b_flush = 1'b0, b_ready = 1'b0;
  logic [23:0] b_flush_pc = '0;
  logic        b_mem_re, b_valid;
  logic [23:0] b_mem_addr, b_rdata, b_instr, b_pc;
  logic [3:0]  b_count;

  fetch_queue #(.ADDR_W(24), .DATA_W(24), .DEPTH(4), .MEM_LAT(1), .RESET_PC(24'h0)) u_dut_a (
    .iw_clk(clk), .iw_rst_n(a_rst_n), .ow_mem_addr(a_mem_addr), .ow_mem_re(a_mem_re),
    .iw_mem_rdata(a_rdata), .iw_flush(a_flush), .iw_flush_pc(a_flush_pc),
    .ow_valid(a_valid), .iw_ready(a_ready), .ow_instr(a_instr), .ow_pc(a_pc),
    .ow_count(a_count));

  fetch_queue #(.ADDR_W(24), .DATA_W(24), .DEPTH(8), .MEM_LAT(3), .RESET_PC(24'h0)) u_dut_b (
    .iw_clk(clk), .iw_rst_n(b_rst_n), .ow_mem_addr(b_mem_addr), .ow_mem_re(b_mem_re),
    .iw_mem_rdata(b_rdata), .iw_flush(b_flush), .iw_flush_pc(b_flush_pc),
    .ow_valid(b_valid), .iw_ready(b_ready), .ow_instr(b_instr), .ow_pc(b_pc),
    .ow_count(b_count));

  function automatic logic [23:0] mem_word(input logic [23:0] a);
    return a ^ 24'hC3A55A;
  endfunction

  // Instruction memory models with fixed read latency.
  logic [23:0] a_pipe;
  logic [23:0] b_pipe [3];
  always @(posedge clk) a_pipe <= mem_word(a_mem_addr);
  always @(posedge clk) begin
    b_pipe[0] <= mem_word(b_mem_addr);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_rdata = a_pipe;
  assign b_rdata = b_pipe[2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: an entry is pushed for every issued read, flushed/reset
  // entries are discarded, and every handshake pops and compares.
  typedef struct packed {
    logic [23:0] pc;
    logic [23:0] instr;
  } sb_t;

  sb_t         sbq0[$];
  sb_t         sbq1[$];
  logic [23:0] exp_issue  [2];
  logic        prev_hold  [2];
  logic [23:0] prev_pc    [2];
  logic [23:0] prev_instr [2];
  int          n_deliv    [2];

  task automatic sb_step(input int k, input logic rst_n, input logic ready, input logic flush,
                         input logic [23:0] flush_pc, input logic mem_re, input logic [23:0] mem_addr,
                         input logic valid, input logic [23:0] pc, input logic [23:0] instr);
    sb_t e;
    int  sz;
    if (prev_hold[k]) begin
      check($sformatf("dut%0d_hold_valid", k), 32'(valid), 32'd1);
      check($sformatf("dut%0d_hold_pc", k), 32'(pc), 32'(prev_pc[k]));
      check($sformatf("dut%0d_hold_instr", k), 32'(instr), 32'(prev_instr[k]));
    end
    if (!rst_n || flush) check($sformatf("dut%0d_re_gated", k), 32'(mem_re), 32'd0);
    if (rst_n && valid && ready && !flush) begin
      sz = (k == 0) ? sbq0.size() : sbq1.size();
      if (sz == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut%0d_unexpected_output: got pc 0x%0h, expected nothing at %0t", k, pc, $time);
      end else begin
        if (k == 0) e = sbq0.pop_front(); else e = sbq1.pop_front();
        check($sformatf("dut%0d_sb_pc", k), 32'(pc), 32'(e.pc));
        check($sformatf("dut%0d_sb_instr", k), 32'(instr), 32'(e.instr));
        n_deliv[k]++;
      end
    end
    if (mem_re) begin
      check($sformatf("dut%0d_issue_addr", k), 32'(mem_addr), 32'(exp_issue[k]));
      e.pc    = exp_issue[k];
      e.instr = mem_word(exp_issue[k]);
      if (k == 0) sbq0.push_back(e); else sbq1.push_back(e);
      exp_issue[k] = exp_issue[k] + 24'd1;
    end
    if (!rst_n || flush) begin
      if (k == 0) sbq0.delete(); else sbq1.delete();
      exp_issue[k] = rst_n ? flush_pc : 24'h0;
    end
    prev_hold[k]  = rst_n && valid && !ready && !flush;
    prev_pc[k]    = pc;
    prev_instr[k] = instr;
  endtask

  always begin
    @(negedge clk);
    #2;
    sb_step(0, a_rst_n, a_ready, a_flush, a_flush_pc, a_mem_re, a_mem_addr, a_valid, a_pc, a_instr);
  end
  always begin
    @(negedge clk);
    #2;
    sb_step(1, b_rst_n, b_ready, b_flush, b_flush_pc, b_mem_re, b_mem_addr, b_valid, b_pc, b_instr);
  end

  // Cycle-by-cycle vectors for DUT A: inputs, then expected outputs seen
  // in that same cycle (pc only checked when valid is expected).
  typedef struct packed {
    logic        rst_n, ready, flush;
    logic [23:0] fpc;
    logic        re;
    logic [23:0] addr;
    logic        valid;
    logic [23:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  localparam int NV = 31;
  vec_t vt [NV];

  function automatic vec_t mk(input logic rst_n, input logic ready, input logic flush,
                              input logic [23:0] fpc, input logic re, input logic [23:0] addr,
                              input logic valid, input logic [23:0] pc, input logic [2:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.ready = ready; v.flush = flush; v.fpc = fpc;
    v.re = re; v.addr = addr; v.valid = valid; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      exp_issue[k] = '0; prev_hold[k] = 1'b0; prev_pc[k] = '0; prev_instr[k] = '0; n_deliv[k] = 0;
    end

    //             rst rdy fl fpc          re addr         v  pc          cnt
    vt[0]  = mk(0, 1, 0, 24'h0,      0, 24'h0,      0, 24'h0,      3'd0);
    vt[1]  = mk(1, 1, 0, 24'h0,      1, 24'h0,      0, 24'h0,      3'd0);
    vt[2]  = mk(1, 1, 0, 24'h0,      1, 24'h1,      0, 24'h0,      3'd0);
    vt[3]  = mk(1, 1, 0, 24'h0,      1, 24'h2,      1, 24'h0,      3'd1);
    vt[4]  = mk(1, 0, 0, 24'h0,      1, 24'h3,      1, 24'h1,      3'd1);
    vt[5]  = mk(1, 0, 0, 24'h0,      1, 24'h4,      1, 24'h1,      3'd2);
    vt[6]  = mk(1, 0, 0, 24'h0,      0, 24'h5,      1, 24'h1,      3'd3);
    vt[7]  = mk(1, 0, 0, 24'h0,      0, 24'h5,      1, 24'h1,      3'd4);
    vt[8]  = mk(1, 0, 0, 24'h0,      0, 24'h5,      1, 24'h1,      3'd4);
    vt[9]  = mk(1, 1, 0, 24'h0,      1, 24'h5,      1, 24'h1,      3'd4);
    vt[10] = mk(1, 1, 0, 24'h0,      1, 24'h6,      1, 24'h2,      3'd3);
    vt[11] = mk(1, 1, 1, 24'h100,    0, 24'h7,      1, 24'h3,      3'd3);
    vt[12] = mk(1, 1, 0, 24'h0,      1, 24'h100,    0, 24'h0,      3'd0);
    vt[13] = mk(1, 1, 0, 24'h0,      1, 24'h101,    0, 24'h0,      3'd0);
    vt[14] = mk(1, 1, 0, 24'h0,      1, 24'h102,    1, 24'h100,    3'd1);
    vt[15] = mk(1, 1, 1, 24'h200,    0, 24'h103,    1, 24'h101,    3'd1);
    vt[16] = mk(1, 1, 1, 24'hFFFFFE, 0, 24'h200,    0, 24'h0,      3'd0);
    vt[17] = mk(1, 1, 0, 24'h0,      1, 24'hFFFFFE, 0, 24'h0,      3'd0);
    vt[18] = mk(1, 1, 0, 24'h0,      1, 24'hFFFFFF, 0, 24'h0,      3'd0);
    vt[19] = mk(1, 1, 0, 24'h0,      1, 24'h0,      1, 24'hFFFFFE, 3'd1);
    vt[20] = mk(1, 1, 0, 24'h0,      1, 24'h1,      1, 24'hFFFFFF, 3'd1);
    vt[21] = mk(1, 1, 0, 24'h0,      1, 24'h2,      1, 24'h0,      3'd1);
    vt[22] = mk(1, 1, 0, 24'h0,      1, 24'h3,      1, 24'h1,      3'd1);
    vt[23] = mk(1, 0, 0, 24'h0,      1, 24'h4,      1, 24'h2,      3'd1);
    vt[24] = mk(1, 0, 0, 24'h0,      1, 24'h5,      1, 24'h2,      3'd2);
    vt[25] = mk(0, 0, 0, 24'h0,      0, 24'h6,      1, 24'h2,      3'd3);
    vt[26] = mk(1, 1, 0, 24'h0,      1, 24'h0,      0, 24'h0,      3'd0);
    vt[27] = mk(1, 1, 0, 24'h0,      1, 24'h1,      0, 24'h0,      3'd0);
    vt[28] = mk(1, 1, 0, 24'h0,      1, 24'h2,      1, 24'h0,      3'd1);
    vt[29] = mk(0, 1, 1, 24'h300,    0, 24'h3,      1, 24'h1,      3'd1);
    vt[30] = mk(1, 1, 0, 24'h0,      1, 24'h0,      0, 24'h0,      3'd0);

    // Initial reset for both DUTs.
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_rst_n = vt[i].rst_n; a_ready = vt[i].ready; a_flush = vt[i].flush; a_flush_pc = vt[i].fpc;
      #1;
      check($sformatf("row%0d_mem_re", i), 32'(a_mem_re), 32'(vt[i].re));
      check($sformatf("row%0d_mem_addr", i), 32'(a_mem_addr), 32'(vt[i].addr));
      check($sformatf("row%0d_valid", i), 32'(a_valid), 32'(vt[i].valid));
      check($sformatf("row%0d_count", i), 32'(a_count), 32'(vt[i].cnt));
      if (vt[i].valid) check($sformatf("row%0d_pc", i), 32'(a_pc), 32'(vt[i].pc));
      if (i == 1 || i == 26 || i == 30) begin
        check($sformatf("row%0d_reset_instr", i), 32'(a_instr), 32'd0);
        check($sformatf("row%0d_reset_pc", i), 32'(a_pc), 32'd0);
      end
    end

    // Random traffic on DUT A, checked by the scoreboard.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      a_rst_n    = ($urandom_range(0, 99) != 0);
      a_ready    = ($urandom_range(0, 3) != 0);
      a_flush    = ($urandom_range(0, 19) == 0);
      a_flush_pc = 24'($urandom);
    end
    @(negedge clk);
    a_rst_n = 1'b0; a_flush = 1'b0; a_ready = 1'b1;

    // DUT B: stream, then flush with reads in flight.
    @(negedge clk);
    b_rst_n = 1'b1; b_ready = 1'b1;
    repeat (12) @(negedge clk);
    b_flush = 1'b1; b_flush_pc = 24'h000100;
    #1;
    check("b_flush_cycle_re", 32'(b_mem_re), 32'd0);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      b_flush = 1'b0;
      #1;
      check($sformatf("b_redirect_valid_f%0d", j), 32'(b_valid), 32'(j == 5));
      if (j == 1) begin
        check("b_redirect_count", 32'(b_count), 32'd0);
        check("b_redirect_issue", 32'(b_mem_addr), 32'h100);
        check("b_redirect_re", 32'(b_mem_re), 32'd1);
      end
      if (j == 5) begin
        check("b_redirect_pc0", 32'(b_pc), 32'h100);
        check("b_redirect_instr0", 32'(b_instr), 32'(mem_word(24'h100)));
      end
    end
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      #1;
      check($sformatf("b_redirect_pc%0d", j), 32'(b_valid ? b_pc : 24'hDEAD), 32'(24'h100 + 24'(j)));
    end

    // Backpressure until full, then reset with a read in flight.
    @(negedge clk);
    b_ready = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("b_full_count", 32'(b_count), 32'd8);
    check("b_full_re", 32'(b_mem_re), 32'd0);
    check("b_full_valid", 32'(b_valid), 32'd1);
    @(negedge clk);
    b_ready = 1'b1;
    #1;
    check("b_drain_re", 32'(b_mem_re), 32'd1);
    @(negedge clk);
    b_ready = 1'b0; b_rst_n = 1'b0;
    #1;
    check("b_prereset_count", 32'(b_count), 32'd7);
    @(negedge clk);
    b_rst_n = 1'b1; b_ready = 1'b1;
    #1;
    check("b_postreset_count", 32'(b_count), 32'd0);
    check("b_postreset_valid", 32'(b_valid), 32'd0);
    check("b_postreset_addr", 32'(b_mem_addr), 32'd0);
    check("b_postreset_re", 32'(b_mem_re), 32'd1);
    repeat (15) @(negedge clk);

    // Random traffic on DUT B.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      b_rst_n    = ($urandom_range(0, 99) != 0);
      b_ready    = ($urandom_range(0, 3) != 0);
      b_flush    = ($urandom_range(0, 19) == 0);
      b_flush_pc = 24'($urandom);
    end
    @(negedge clk);
    b_rst_n = 1'b0; b_flush = 1'b0;
    repeat (2) @(negedge clk);

    check("a_delivered_enough", 32'(n_deliv[0] > 50), 32'd1);
    check("b_delivered_enough", 32'(n_deliv[1] > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
